// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern driver: command modes and handshake FSM states.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

endpackage

// File: rtl/led_pwm_core.sv
// PWM counter, brightness compare and registered LED output.
// The counter period is 2^PWM_BITS-1, so an all-ones level stays high through the wrap.
module led_pwm_core #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [PWM_BITS-1:0] eff_level_i,
  output logic                led_o,
  output logic                wrap_o
);

  localparam logic [PWM_BITS-1:0] CNT_ONE = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] CNT_MAX = ~CNT_ONE;

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                led_q, led_d;

  always_comb begin
    pwm_cnt_d = (pwm_cnt_q == CNT_MAX) ? '0 : pwm_cnt_q + CNT_ONE;
    led_d     = (pwm_cnt_q < eff_level_i);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pwm_cnt_q <= '0;
      led_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
    end
  end

  assign led_o  = led_q;
  assign wrap_o = (pwm_cnt_q == '0);

endmodule

// File: rtl/led_pattern_driver.sv
// Command-driven LED stage: valid/ready command intake, wrap-aligned apply, and
// OFF/ON/BLINK/BREATHE pattern generation feeding the PWM core.
module led_pattern_driver #(
  parameter int PWM_BITS = 8,
  parameter int TICK_DIV = 50000,
  parameter int RATE_W   = 8
) (
  input  logic                clk_50,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mode,
  input  logic [PWM_BITS-1:0] cmd_level,
  input  logic [RATE_W-1:0]   cmd_rate,
  output logic                led_o,
  output logic                busy_o
);
  import led_pkg::*;

  localparam int                  PRESC_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [PRESC_W-1:0]  PRESC_ONE = PRESC_W'(1);
  localparam logic [RATE_W-1:0]   RATE_ONE  = RATE_W'(1);
  localparam logic [PWM_BITS-1:0] LVL_ONE   = PWM_BITS'(1);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e              state_q, state_d;
  mode_e               sh_mode_q, act_mode_q, act_mode_d;
  logic [PWM_BITS-1:0] sh_level_q, act_level_q, act_level_d;
  logic [RATE_W-1:0]   sh_rate_q, act_rate_q, act_rate_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [RATE_W-1:0]   step_cnt_q, step_cnt_d;
  logic                phase_on_q, phase_on_d;
  logic [PWM_BITS-1:0] ramp_q, ramp_d;
  logic                ramp_up_q, ramp_up_d;
  logic [PWM_BITS-1:0] eff_level;
  logic                wrap, tick, step, accept, apply;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy_o    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        busy_o = 1'b1;
        if (wrap) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = cmd_valid && cmd_ready;
  assign apply  = (state_q == ST_PENDING) && wrap;
  assign tick   = (presc_q == PRESC_MAX);
  assign step   = tick && (step_cnt_q == act_rate_q);

  always_comb begin
    presc_d     = tick ? '0 : presc_q + PRESC_ONE;
    act_mode_d  = act_mode_q;
    act_level_d = act_level_q;
    act_rate_d  = act_rate_q;
    step_cnt_d  = step_cnt_q;
    phase_on_d  = phase_on_q;
    ramp_d      = ramp_q;
    ramp_up_d   = ramp_up_q;
    if (apply) begin
      act_mode_d  = sh_mode_q;
      act_level_d = sh_level_q;
      act_rate_d  = sh_rate_q;
      step_cnt_d  = '0;
      phase_on_d  = 1'b1;
      ramp_d      = '0;
      ramp_up_d   = 1'b1;
    end else if (tick) begin
      step_cnt_d = step ? '0 : step_cnt_q + RATE_ONE;
      if (step) begin
        phase_on_d = ~phase_on_q;
        // The ramp saturates at level and 0; direction flips on reaching either end.
        if (ramp_up_q) begin
          if (ramp_q >= act_level_q) begin
            ramp_up_d = 1'b0;
          end else begin
            ramp_d = ramp_q + LVL_ONE;
            if (ramp_q + LVL_ONE == act_level_q) ramp_up_d = 1'b0;
          end
        end else begin
          if (ramp_q == '0) begin
            ramp_up_d = 1'b1;
          end else begin
            ramp_d = ramp_q - LVL_ONE;
            if (ramp_q == LVL_ONE) ramp_up_d = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    eff_level = '0;
    unique case (act_mode_q)
      MODE_ON:      eff_level = act_level_q;
      MODE_BLINK:   eff_level = phase_on_q ? act_level_q : '0;
      MODE_BREATHE: eff_level = ramp_q;
      default:      eff_level = '0;
    endcase
  end

  // NOTE: only a handful of flops, no memories, so everything is reset to a known state.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sh_mode_q   <= MODE_OFF;
      sh_level_q  <= '0;
      sh_rate_q   <= '0;
      act_mode_q  <= MODE_OFF;
      act_level_q <= '0;
      act_rate_q  <= '0;
      presc_q     <= '0;
      step_cnt_q  <= '0;
      phase_on_q  <= 1'b1;
      ramp_q      <= '0;
      ramp_up_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      if (accept) begin
        sh_mode_q  <= mode_e'(cmd_mode);
        sh_level_q <= cmd_level;
        sh_rate_q  <= cmd_rate;
      end
      act_mode_q  <= act_mode_d;
      act_level_q <= act_level_d;
      act_rate_q  <= act_rate_d;
      presc_q     <= presc_d;
      step_cnt_q  <= step_cnt_d;
      phase_on_q  <= phase_on_d;
      ramp_q      <= ramp_d;
      ramp_up_q   <= ramp_up_d;
    end
  end

  led_pwm_core #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk_i      (clk_50),
    .rst_ni     (rst_n),
    .eff_level_i(eff_level),
    .led_o      (led_o),
    .wrap_o     (wrap)
  );

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench for led_pattern_driver with PWM_BITS=4, TICK_DIV=4, RATE_W=8.
// Timing reference: after reset release, posedge n puts the PWM counter at (n-2) mod 15.
module tb_led_pattern_driver;

  localparam int PWM_BITS = 4;
  localparam int TICK_DIV = 4;
  localparam int RATE_W   = 8;
  localparam int PERIOD   = 15;

  logic                clk_50    = 1'b0;
  logic                reset_n   = 1'b1;
  logic                cmd_valid = 1'b0;
  logic [1:0]          cmd_mode  = '0;
  logic [PWM_BITS-1:0] cmd_level = '0;
  logic [RATE_W-1:0]   cmd_rate  = '0;
  logic                cmd_ready, led_o, busy_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  led_pattern_driver #(
    .PWM_BITS(PWM_BITS),
    .TICK_DIV(TICK_DIV),
    .RATE_W  (RATE_W)
  ) dut (
    .clk_50   (clk_50),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_mode (cmd_mode),
    .cmd_level(cmd_level),
    .cmd_rate (cmd_rate),
    .led_o    (led_o),
    .busy_o   (busy_o)
  );

  always #10 clk_50 = ~clk_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step_clk();
    @(posedge clk_50);
    #1;
    cyc++;
  endtask

  function automatic int cur_cnt();
    return (cyc < 2) ? 0 : (cyc - 2) % PERIOD;
  endfunction

  function automatic bit cur_tick();
    return (cyc >= 2) && (((cyc - 2) % TICK_DIV) == TICK_DIV - 1);
  endfunction

  // Closed-form brightness after k pattern ticks since apply.
  function automatic int exp_eff(input int mode, input int level, input int rate, input int k);
    int s, p;
    s = k / (rate + 1);
    case (mode)
      1:       return level;
      2:       return (s % 2 == 0) ? level : 0;
      3: begin
        if (level == 0) return 0;
        p = s % (2 * level);
        return (p <= level) ? p : 2 * level - p;
      end
      default: return 0;
    endcase
  endfunction

  task automatic do_reset(input int hold, input string tag);
    reset_n = 1'b0;
    #2;
    check({tag, "_async_led"},   led_o,     0);
    check({tag, "_async_ready"}, cmd_ready, 1);
    check({tag, "_async_busy"},  busy_o,    0);
    repeat (hold) step_clk();
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step_clk();
      check({tag, "_led"}, led_o, 0);
    end
    check({tag, "_ready"}, cmd_ready, 1);
    check({tag, "_busy"},  busy_o,    0);
  endtask

  // Issue a command on the cycle the counter sits at slot; exp_steps counts edges
  // from the accepting edge up to the first cycle with busy_o low.
  task automatic send(input int mode, input int level, input int rate, input int slot,
                      input int exp_steps, input string tag);
    int n;
    n = 0;
    while (!(cur_cnt() == slot && cmd_ready === 1'b1) && n < 60) begin
      step_clk();
      n++;
    end
    check({tag, "_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_mode  = 2'(mode);
    cmd_level = PWM_BITS'(level);
    cmd_rate  = RATE_W'(rate);
    step_clk();
    cmd_valid = 1'b0;
    check({tag, "_ready_low"}, cmd_ready, 0);
    check({tag, "_busy_high"}, busy_o,    1);
    n = 1;
    while (busy_o === 1'b1 && n < 40) begin
      step_clk();
      n++;
    end
    check({tag, "_latency"}, n, exp_steps);
  endtask

  // Starts on the first cycle the new pattern is active; led_o lags the compare by one cycle.
  task automatic run_pattern(input int mode, input int level, input int rate, input int n,
                             input string tag, output int highs);
    int k;
    bit raw;
    k = 0;
    highs = 0;
    raw = (cur_cnt() < exp_eff(mode, level, rate, k));
    if (cur_tick()) k++;
    for (int i = 0; i < n; i++) begin
      step_clk();
      check(tag, led_o, raw);
      if (led_o === 1'b1) highs++;
      raw = (cur_cnt() < exp_eff(mode, level, rate, k));
      if (cur_tick()) k++;
    end
  endtask

  initial begin
    int highs, n_acc, second_cnt, n;

    #3;
    do_reset(3, "por");
    idle_check(100, "por_idle");

    send(1, 5, 0, 7, 9, "on5");
    run_pattern(1, 5, 0, 30, "on5_led", highs);
    check("on5_duty", highs, 10);

    send(1, 15, 0, 14, 2, "on15");
    run_pattern(1, 15, 0, 30, "on15_led", highs);
    check("on15_duty", highs, 30);

    do_reset(4, "midrst");
    idle_check(100, "midrst_idle");

    send(2, 15, 1, 0, 16, "blink");
    run_pattern(2, 15, 1, 64, "blink_led", highs);

    send(3, 3, 0, 3, 13, "breathe3");
    run_pattern(3, 3, 0, 90, "breathe3_led", highs);

    send(3, 0, 0, 10, 6, "breathe0");
    run_pattern(3, 0, 0, 60, "breathe0_led", highs);
    check("breathe0_duty", highs, 0);

    // Valid held through PENDING with a new payload after the first accept.
    n = 0;
    while (!(cur_cnt() == 5 && cmd_ready === 1'b1) && n < 60) begin
      step_clk();
      n++;
    end
    cmd_valid  = 1'b1;
    cmd_mode   = 2'd0;
    cmd_level  = '0;
    cmd_rate   = '0;
    n_acc      = 0;
    second_cnt = -1;
    for (int i = 0; i < 40 && n_acc < 2; i++) begin
      if (cmd_ready === 1'b1) begin
        n_acc++;
        if (n_acc == 2) second_cnt = cur_cnt();
      end
      step_clk();
      if (n_acc == 1) begin
        cmd_mode  = 2'd1;
        cmd_level = 4'd15;
      end
    end
    cmd_valid = 1'b0;
    check("hs_accepts",     n_acc,      2);
    check("hs_second_slot", second_cnt, 1);
    check("hs_busy_again",  busy_o,     1);
    n = 1;
    while (busy_o === 1'b1 && n < 40) begin
      step_clk();
      n++;
    end
    check("hs_second_latency", n, 15);
    run_pattern(1, 15, 0, 30, "hs_on15_led", highs);
    check("hs_on15_duty", highs, 30);

    // Reset while a BLINK command is pending must drop it.
    n = 0;
    while (!(cur_cnt() == 2 && cmd_ready === 1'b1) && n < 60) begin
      step_clk();
      n++;
    end
    cmd_valid = 1'b1;
    cmd_mode  = 2'd2;
    cmd_level = 4'd15;
    cmd_rate  = 8'd0;
    step_clk();
    cmd_valid = 1'b0;
    check("pendrst_busy", busy_o, 1);
    repeat (3) step_clk();
    do_reset(2, "pendrst");
    idle_check(60, "pendrst_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
